// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with start/done handshake, stored carry
// for ADC/SBC chains and a multi-cycle unsigned shift-add multiplier.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] r_hi,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic             carry,
    output logic             sign,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_ADC = 4'b0010;
    localparam logic [3:0] OP_SBC = 4'b0011;
    localparam logic [3:0] OP_NEG = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1000;
    localparam logic [3:0] OP_SHL = 4'b1001;
    localparam logic [3:0] OP_SHR = 4'b1010;
    localparam logic [3:0] OP_MUL = 4'b1011;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic [CW-1:0]    iter_r, iter_s;
    logic [WIDTH-1:0] mcand_r, mcand_s;
    logic [WIDTH-1:0] acc_hi_r, acc_hi_s;
    logic [WIDTH-1:0] acc_lo_r, acc_lo_s;
    logic [WIDTH-1:0] r_r, r_s;
    logic [WIDTH-1:0] r_hi_r, r_hi_s;
    logic             done_r, done_s;
    logic             zero_r, zero_s;
    logic             carry_r, carry_s;
    logic             sign_r, sign_s;
    logic             ovf_r, ovf_s;

    // Adder operand selection: every arithmetic op is x + y + cin.
    logic [WIDTH-1:0] add_x_s, add_y_s;
    logic             add_cin_s;
    logic [WIDTH:0]   add_sum_s;
    logic             add_ovf_s;

    // Single-cycle result path.
    logic [WIDTH-1:0] res_s;
    logic             res_carry_s;
    logic             res_ovf_s;

    // One shift-add multiplier iteration.
    logic [WIDTH:0]   mul_add_s;
    logic [WIDTH-1:0] step_hi_s, step_lo_s;

    // Pick adder operands and carry-in from the opcode.
    always_comb begin
        add_x_s   = a;
        add_y_s   = b;
        add_cin_s = 1'b0;
        case (op)
            OP_ADD: begin add_x_s = a; add_y_s = b;  add_cin_s = 1'b0;    end
            OP_SUB: begin add_x_s = a; add_y_s = ~b; add_cin_s = 1'b1;    end
            OP_ADC: begin add_x_s = a; add_y_s = b;  add_cin_s = carry_r; end
            OP_SBC: begin add_x_s = a; add_y_s = ~b; add_cin_s = carry_r; end
            OP_NEG: begin add_x_s = {WIDTH{1'b0}}; add_y_s = ~a; add_cin_s = 1'b1; end
            default: begin add_x_s = a; add_y_s = b; add_cin_s = 1'b0; end
        endcase
        add_sum_s = {1'b0, add_x_s} + {1'b0, add_y_s} + {{WIDTH{1'b0}}, add_cin_s};
        add_ovf_s = (add_x_s[WIDTH-1] == add_y_s[WIDTH-1]) &&
                    (add_sum_s[WIDTH-1] != add_x_s[WIDTH-1]);
    end

    // Result, carry and overflow for the ops that complete in one cycle.
    always_comb begin
        res_s       = r_r;
        res_carry_s = carry_r;
        res_ovf_s   = ovf_r;
        case (op)
            OP_ADD, OP_SUB, OP_ADC, OP_SBC, OP_NEG: begin
                res_s       = add_sum_s[WIDTH-1:0];
                res_carry_s = add_sum_s[WIDTH];
                res_ovf_s   = add_ovf_s;
            end
            OP_AND: begin res_s = a & b; res_carry_s = 1'b0; res_ovf_s = 1'b0; end
            OP_OR:  begin res_s = a | b; res_carry_s = 1'b0; res_ovf_s = 1'b0; end
            OP_XOR: begin res_s = a ^ b; res_carry_s = 1'b0; res_ovf_s = 1'b0; end
            OP_NOT: begin res_s = ~a;    res_carry_s = 1'b0; res_ovf_s = 1'b0; end
            OP_SHL: begin
                res_s       = {a[WIDTH-2:0], 1'b0};
                res_carry_s = a[WIDTH-1];
                res_ovf_s   = 1'b0;
            end
            OP_SHR: begin
                res_s       = {1'b0, a[WIDTH-1:1]};
                res_carry_s = a[0];
                res_ovf_s   = 1'b0;
            end
            default: begin
                res_s       = r_r;
                res_carry_s = carry_r;
                res_ovf_s   = ovf_r;
            end
        endcase
    end

    // Multiplier step: conditionally add the multiplicand into the high
    // half, then shift {carry, hi, lo} right by one.
    always_comb begin
        if (acc_lo_r[0]) begin
            mul_add_s = {1'b0, acc_hi_r} + {1'b0, mcand_r};
        end else begin
            mul_add_s = {1'b0, acc_hi_r};
        end
        step_hi_s = mul_add_s[WIDTH:1];
        step_lo_s = {mul_add_s[0], acc_lo_r[WIDTH-1:1]};
    end

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        state_s  = state_r;
        iter_s   = iter_r;
        mcand_s  = mcand_r;
        acc_hi_s = acc_hi_r;
        acc_lo_s = acc_lo_r;
        r_s      = r_r;
        r_hi_s   = r_hi_r;
        done_s   = 1'b0;
        zero_s   = zero_r;
        carry_s  = carry_r;
        sign_s   = sign_r;
        ovf_s    = ovf_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        state_s  = ST_MUL;
                        iter_s   = {CW{1'b0}};
                        mcand_s  = a;
                        acc_hi_s = {WIDTH{1'b0}};
                        acc_lo_s = b;
                    end else if (op[3:2] == 2'b11) begin
                        done_s = 1'b1;
                    end else begin
                        r_s     = res_s;
                        r_hi_s  = {WIDTH{1'b0}};
                        zero_s  = (res_s == {WIDTH{1'b0}});
                        carry_s = res_carry_s;
                        sign_s  = res_s[WIDTH-1];
                        ovf_s   = res_ovf_s;
                        done_s  = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                acc_hi_s = step_hi_s;
                acc_lo_s = step_lo_s;
                iter_s   = iter_r + CW'(1);
                if (iter_r == CW'(WIDTH - 1)) begin
                    state_s = ST_IDLE;
                    r_s     = step_lo_s;
                    r_hi_s  = step_hi_s;
                    zero_s  = ({step_hi_s, step_lo_s} == {(2 * WIDTH){1'b0}});
                    carry_s = (step_hi_s != {WIDTH{1'b0}});
                    sign_s  = step_hi_s[WIDTH-1];
                    ovf_s   = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_MUL;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            iter_r   <= {CW{1'b0}};
            mcand_r  <= {WIDTH{1'b0}};
            acc_hi_r <= {WIDTH{1'b0}};
            acc_lo_r <= {WIDTH{1'b0}};
            r_r      <= {WIDTH{1'b0}};
            r_hi_r   <= {WIDTH{1'b0}};
            done_r   <= 1'b0;
            zero_r   <= 1'b0;
            carry_r  <= 1'b0;
            sign_r   <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            iter_r   <= iter_s;
            mcand_r  <= mcand_s;
            acc_hi_r <= acc_hi_s;
            acc_lo_r <= acc_lo_s;
            r_r      <= r_s;
            r_hi_r   <= r_hi_s;
            done_r   <= done_s;
            zero_r   <= zero_s;
            carry_r  <= carry_s;
            sign_r   <= sign_s;
            ovf_r    <= ovf_s;
        end
    end

    assign r     = r_r;
    assign r_hi  = r_hi_r;
    assign busy  = (state_r == ST_MUL);
    assign done  = done_r;
    assign zero  = zero_r;
    assign carry = carry_r;
    assign sign  = sign_r;
    assign ovf   = ovf_r;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq (WIDTH=4) against
// an arithmetic reference model of the operation rules.
module tb_alu_seq;

    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;
    localparam int HALF = 1 << (W - 1);

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] a, b, r, r_hi;
    logic         busy, done, zero, carry, sign, ovf;

    int vec_cnt = 0;
    int err_cnt = 0;

    // reference state
    int m_r, m_hi;
    int m_z, m_c, m_s, m_v;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .r(r), .r_hi(r_hi), .busy(busy), .done(done),
        .zero(zero), .carry(carry), .sign(sign), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int to_signed(input int v);
        return (v >= HALF) ? v - (1 << W) : v;
    endfunction

    task automatic model_reset();
        m_r = 0; m_hi = 0; m_z = 0; m_c = 0; m_s = 0; m_v = 0;
    endtask

    // Reference: compute result and flags from the operation rules.
    task automatic model_op(input int o, input int x, input int y);
        int ex, ey, cin, s, ss, p;
        bit arith;
        arith = 1'b0; ex = 0; ey = 0; cin = 0;
        case (o)
            0: begin arith = 1'b1; ex = x; ey = y;          cin = 1;   cin = 0; end
            1: begin arith = 1'b1; ex = x; ey = ~y & MASK;  cin = 1;   end
            2: begin arith = 1'b1; ex = x; ey = y;          cin = m_c; end
            3: begin arith = 1'b1; ex = x; ey = ~y & MASK;  cin = m_c; end
            4: begin arith = 1'b1; ex = 0; ey = ~x & MASK;  cin = 1;   end
            default: arith = 1'b0;
        endcase
        if (o >= 12) return;  // NOP: everything holds
        if (o == 11) begin
            p    = x * y;
            m_r  = p & MASK;
            m_hi = p >> W;
            m_c  = (m_hi != 0);
            m_z  = (p == 0);
            m_s  = (m_hi >> (W - 1)) & 1;
            m_v  = 0;
            return;
        end
        if (arith) begin
            s   = ex + ey + cin;
            m_r = s & MASK;
            m_c = (s >> W) & 1;
            ss  = to_signed(ex) + to_signed(ey) + cin;
            m_v = (ss > HALF - 1) || (ss < -HALF);
        end else begin
            m_v = 0;
            case (o)
                5:  begin m_r = x & y;        m_c = 0; end
                6:  begin m_r = x | y;        m_c = 0; end
                7:  begin m_r = x ^ y;        m_c = 0; end
                8:  begin m_r = ~x & MASK;    m_c = 0; end
                9:  begin m_r = (x << 1) & MASK; m_c = (x >> (W - 1)) & 1; end
                default: begin m_r = x >> 1;  m_c = x & 1; end
            endcase
        end
        m_hi = 0;
        m_z  = (m_r == 0);
        m_s  = (m_r >> (W - 1)) & 1;
    endtask

    task automatic check_result(input string tag);
        check_eq({tag, "_r"},     32'(r),    32'(m_r));
        check_eq({tag, "_r_hi"},  32'(r_hi), 32'(m_hi));
        check_eq({tag, "_flags"}, 32'({zero, carry, sign, ovf}),
                 32'({m_z[0], m_c[0], m_s[0], m_v[0]}));
        check_eq({tag, "_done"},  32'({done, busy}), 32'(2'b10));
    endtask

    // Issue one op; for MUL, optionally wiggle inputs and start while busy.
    task automatic run_op(input int o, input int x, input int y, input bit noisy);
        start = 1'b1;
        op    = 4'(o);
        a     = W'(x);
        b     = W'(y);
        tick();
        start = 1'b0;
        model_op(o, x, y);
        if (o == 11) begin
            for (int i = 0; i < W; i++) begin
                check_eq("mul_busy", 32'({busy, done}), 32'(2'b10));
                if (noisy) begin
                    start = 1'($urandom_range(0, 1));
                    op    = 4'($urandom_range(0, 15));
                    a     = W'($urandom);
                    b     = W'($urandom);
                end
                tick();
            end
            start = 1'b0;
        end
        check_result($sformatf("op%0d", o));
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        op      = 4'd0;
        a       = '0;
        b       = '0;
        model_reset();
        tick();
        tick();
        check_eq("reset_outs", 32'({r, r_hi, busy, done, zero, carry, sign, ovf}), 32'd0);
        reset_n = 1'b1;
        tick();

        // directed test plan
        run_op(0, 9, 8, 1'b0);
        check_eq("tp_add_ovf", 32'({r, carry, ovf, sign, zero}), 32'({4'd1, 4'b1100}));
        run_op(1, 5, 5, 1'b0);
        check_eq("tp_sub_zero", 32'({r, zero, carry, ovf}), 32'({4'd0, 3'b110}));
        run_op(4, 8, 0, 1'b0);
        check_eq("tp_neg_min", 32'({r, ovf, sign}), 32'({4'd8, 2'b11}));
        run_op(0, 15, 1, 1'b0);
        run_op(2, 0, 0, 1'b0);
        check_eq("tp_adc", 32'({r, carry}), 32'({4'd1, 1'b0}));
        run_op(3, 0, 0, 1'b0);
        check_eq("tp_sbc", 32'({r, carry, sign}), 32'({4'hF, 2'b01}));
        run_op(11, 15, 15, 1'b1);
        check_eq("tp_mul_ff", 32'({r_hi, r, carry, zero}), 32'({4'hE, 4'h1, 2'b10}));
        tick();
        check_eq("tp_no_extra_done", 32'(done), 32'd0);
        run_op(11, 0, 7, 1'b0);
        check_eq("tp_mul_zero", 32'({r_hi, r, zero, carry}), 32'({8'h00, 2'b10}));
        run_op(13, 3, 3, 1'b0);

        // reset in the middle of a MUL
        start = 1'b1; op = 4'd11; a = 4'hF; b = 4'hF;
        tick();
        start = 1'b0;
        tick();
        reset_n = 1'b0;
        tick();
        model_reset();
        check_eq("midmul_reset", 32'({r, r_hi, busy, done, zero, carry, sign, ovf}), 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < W + 1; i++) begin
            tick();
            check_eq("midmul_quiet", 32'({busy, done}), 32'd0);
        end
        run_op(0, 2, 3, 1'b0);
        check_eq("post_reset_add", 32'(r), 32'd5);

        // randomized ops, mixing back-to-back issue and idle gaps
        for (int n = 0; n < 300; n++) begin
            run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, MASK)),
                   int'($urandom_range(0, MASK)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 0) begin
                tick();
                check_eq("idle_hold", 32'({r, r_hi, done, busy}),
                         32'({W'(m_r), W'(m_hi), 2'b00}));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
